// File: rtl/ram_op_sequencer_pkg.sv
// Shared definitions for the RAM operation sequencer: command encodings,
// controller states and a counter sizing helper.
package ram_op_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'd0,
      OP_SQR  = 2'd1,
      OP_COPY = 2'd2,
      OP_NOP  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_ISSUE,
      S_BUSY,
      S_WB,
      S_FIN
   } state_e;

   // Bits needed to count 0..tmo-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned tmo);
      return (tmo < 2) ? 1 : $clog2(tmo);
   endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Cycle counter for the multiplier wait: cleared by load, advanced by en,
// expire flags the last permitted cycle while en is high.
module seq_timeout_cnt
   import ram_op_sequencer_pkg::*;
#(
   parameter int unsigned TMO = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int unsigned    CW   = cnt_width(TMO);
   localparam logic [CW-1:0]  LAST = CW'(TMO - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   logic [CW-1:0] cnt;

   // NOTE: asynchronous active-low reset lives in the sensitivity list; the
   // first branch must test it so the flop clears without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + ONE;
      end
   end

   // cnt equals the number of BUSY cycles already completed.
   assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ram_op_sequencer.sv
// Sequences one RAM read, an optional multiply and one RAM write-back per
// command; every output comes straight from a flop.
module ram_op_sequencer
   import ram_op_sequencer_pkg::*;
#(
   parameter int unsigned DATA = 256,
   parameter int unsigned ADDR = 3,
   parameter int unsigned TMO  = 1023
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [ADDR-1:0] cmd_src1,
   input  logic [ADDR-1:0] cmd_src2,
   input  logic [ADDR-1:0] cmd_dst,
   output logic            done,
   output logic            err,
   output logic            ram_a_w,
   output logic            ram_b_w,
   output logic [ADDR-1:0] ram_a_adbus,
   output logic [ADDR-1:0] ram_b_adbus,
   output logic [DATA-1:0] ram_a_din,
   input  logic [DATA-1:0] ram_a_dout,
   input  logic [DATA-1:0] ram_b_dout,
   output logic            mul_start,
   output logic [DATA-1:0] mul_a,
   output logic [DATA-1:0] mul_b,
   input  logic            mul_done,
   input  logic [DATA-1:0] mul_res
);

   state_e          state, state_d;
   op_e             op_q;
   logic [ADDR-1:0] dst_q;
   logic [DATA-1:0] result_q;
   logic [DATA-1:0] wb_data;
   logic            accept;
   logic            timeout;

   assign accept  = cmd_valid && cmd_ready && (state == S_IDLE);
   assign wb_data = (state == S_BUSY) ? mul_res : ram_a_dout;

   seq_timeout_cnt #(
      .TMO (TMO)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state == S_ISSUE),
      .en     (state == S_BUSY),
      .expire (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:  if (accept) state_d = (op_e'(cmd_op) == OP_NOP) ? S_FIN : S_RD;
         S_RD:    state_d = S_WT;
         S_WT:    state_d = (op_q == OP_COPY) ? S_WB : S_ISSUE;
         S_ISSUE: state_d = S_BUSY;
         S_BUSY: begin
            if (mul_done)     state_d = S_WB;
            else if (timeout) state_d = S_FIN;
         end
         S_WB:    state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered against state_d so each is valid during the state
   // it belongs to; done is the exception and follows FIN by one cycle.
   // NOTE: every flop here uses <= so all of them sample the same pre-edge
   // values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready   <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         mul_start   <= 1'b0;
         ram_a_w     <= 1'b0;
         ram_a_adbus <= '0;
         ram_b_adbus <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         op_q        <= OP_MUL;
         dst_q       <= '0;
         result_q    <= '0;
      end else begin
         cmd_ready <= (state_d == S_IDLE);
         done      <= (state == S_FIN);
         mul_start <= (state_d == S_ISSUE);
         ram_a_w   <= (state_d == S_WB);
         err       <= err || (timeout && !mul_done);

         if (accept) begin
            op_q  <= op_e'(cmd_op);
            dst_q <= cmd_dst;
         end

         // The address registers double as the captured source fields.
         if (state_d == S_RD) begin
            ram_a_adbus <= cmd_src1;
            ram_b_adbus <= (op_e'(cmd_op) == OP_SQR) ? cmd_src1 : cmd_src2;
         end

         if (state == S_WT) begin
            mul_a <= ram_a_dout;
            mul_b <= (op_q == OP_SQR) ? ram_a_dout : ram_b_dout;
         end

         if (state_d == S_WB) begin
            ram_a_adbus <= dst_q;
            result_q    <= wb_data;
         end
      end
   end

   assign ram_a_din = result_q;
   assign ram_b_w   = 1'b0;

endmodule

// File: tb/tb_ram_op_sequencer.sv
// Bench for ram_op_sequencer: 8-word registered RAM model, variable-latency
// multiplier stub, directed scenarios then random commands against a model.
module tb_ram_op_sequencer;

   localparam int DATA = 256;
   localparam int ADDR = 3;
   localparam int TMO  = 15;

   localparam logic [1:0] C_MUL  = 2'd0;
   localparam logic [1:0] C_SQR  = 2'd1;
   localparam logic [1:0] C_COPY = 2'd2;
   localparam logic [1:0] C_NOP  = 2'd3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready;
   logic [1:0]      cmd_op;
   logic [ADDR-1:0] cmd_src1, cmd_src2, cmd_dst;
   logic            done, err, ram_a_w, ram_b_w;
   logic [ADDR-1:0] ram_a_adbus, ram_b_adbus;
   logic [DATA-1:0] ram_a_din, ram_a_dout, ram_b_dout;
   logic            mul_start, mul_done;
   logic [DATA-1:0] mul_a, mul_b, mul_res;

   always #5 clk = ~clk;

   ram_op_sequencer #(.DATA(DATA), .ADDR(ADDR), .TMO(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_src1    (cmd_src1),
      .cmd_src2    (cmd_src2),
      .cmd_dst     (cmd_dst),
      .done        (done),
      .err         (err),
      .ram_a_w     (ram_a_w),
      .ram_b_w     (ram_b_w),
      .ram_a_adbus (ram_a_adbus),
      .ram_b_adbus (ram_b_adbus),
      .ram_a_din   (ram_a_din),
      .ram_a_dout  (ram_a_dout),
      .ram_b_dout  (ram_b_dout),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_done    (mul_done),
      .mul_res     (mul_res)
   );

   // RAM model with a side port the bench uses to preload words.
   logic [DATA-1:0] mem [8] = '{default: '0};
   logic            tb_we;
   logic [ADDR-1:0] tb_wa;
   logic [DATA-1:0] tb_wd;
   int unsigned     wr_cnt = 0, bw_cnt = 0;

   always @(posedge clk) begin
      ram_a_dout <= mem[ram_a_adbus];
      ram_b_dout <= mem[ram_b_adbus];
      if (ram_a_w) begin
         mem[ram_a_adbus] <= ram_a_din;
         wr_cnt <= wr_cnt + 1;
      end
      if (ram_b_w) bw_cnt <= bw_cnt + 1;
      if (tb_we) mem[tb_wa] <= tb_wd;
   end

   // Multiplier stub: mul_done rises stub_lat cycles after mul_start rises.
   int   stub_lat = 3;
   bit   stub_mute = 1'b0;
   int   stub_cnt = 0;
   logic stub_done = 1'b0;
   logic spur;

   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (mul_start) begin
         if (stub_lat <= 1) begin
            stub_done <= !stub_mute;
            mul_res   <= mul_a * mul_b;
            stub_cnt  <= 0;
         end else begin
            stub_cnt <= stub_lat - 1;
         end
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            stub_done <= !stub_mute;
            mul_res   <= mul_a * mul_b;
         end
      end
   end

   assign mul_done = stub_done | spur;

   // Event monitor; cycle stamps are the edge index at which a value is sampled.
   int          cyc = 0, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
   int unsigned acc_cnt = 0, done_cnt = 0, start_cnt = 0, ready_viol = 0;
   logic        in_flight = 1'b0, err_prev = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      err_prev <= err;
      if (err && !err_prev) err_cyc <= cyc;
      if (mul_start) start_cnt <= start_cnt + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (in_flight && cmd_ready && !done) ready_viol <= ready_viol + 1;
      if (!rst_n)                       in_flight <= 1'b0;
      else if (cmd_valid && cmd_ready)  in_flight <= 1'b1;
      else if (done)                    in_flight <= 1'b0;
      if (cmd_valid && cmd_ready) begin
         acc_cnt <= acc_cnt + 1;
         acc_cyc <= cyc;
      end
   end

   int              checks = 0, errors = 0;
   logic [DATA-1:0] ref_mem [8] = '{default: '0};

   task automatic check(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(posedge clk);
      #1 tb_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic send(input logic [1:0] op, input logic [ADDR-1:0] s1, s2, d);
      int n = 0;
      @(negedge clk);
      cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_bounded", n < 50, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, n < 200, 1);
      @(posedge clk);
      #1;
   endtask

   // Latency counts edges from the accept edge to the edge done rises on.
   task automatic run_cmd(input logic [1:0] op, input logic [ADDR-1:0] s1, s2, d,
                          input int exp_lat, input string tag);
      send(op, s1, s2, d);
      wait_done(tag);
      check({tag, "_latency"}, done_cyc - acc_cyc - 1, exp_lat);
   endtask

   function automatic logic [DATA-1:0] rand_word();
      logic [DATA-1:0] w;
      for (int i = 0; i < DATA / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned s_start, s_wr, s_done, s_acc, s_viol;
      int          n;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
      cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
      tb_we = 1'b0; tb_wa = '0; tb_wd = '0; spur = 1'b0;

      #2;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ram_a_w", ram_a_w, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_adbus", {ram_a_adbus, ram_b_adbus}, 0);
      check("rst_mul_ops", mul_a | mul_b | ram_a_din, 0);
      @(posedge clk);
      #1 check("rst_ready_held", cmd_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("ready_before_clk", cmd_ready, 0);
      @(negedge clk);
      check("ready_after_release", cmd_ready, 1);

      poke(3'd1, 5);
      poke(3'd2, 7);

      // MUL 5*7 into word 3.
      s_start = start_cnt; s_wr = wr_cnt;
      run_cmd(C_MUL, 3'd1, 3'd2, 3'd3, 8, "mul");
      ref_mem[3] = 35;
      check("mul_result", mem[3], 35);
      check("mul_start_once", start_cnt - s_start, 1);
      check("mul_one_write", wr_cnt - s_wr, 1);

      // SQR with src2 pointing at a zero word, result overwrites its source.
      run_cmd(C_SQR, 3'd2, 3'd5, 3'd2, 8, "sqr");
      ref_mem[2] = 49;
      check("sqr_result", mem[2], 49);
      check("ram_b_w_never", bw_cnt, 0);

      // COPY with a spurious mul_done held high the whole time.
      s_start = start_cnt;
      spur = 1'b1;
      run_cmd(C_COPY, 3'd1, 3'd4, 3'd7, 4, "copy");
      spur = 1'b0;
      ref_mem[7] = 5;
      check("copy_result", mem[7], 5);
      check("copy_no_start", start_cnt - s_start, 0);

      // Reserved op: done after one cycle, nothing touched.
      s_start = start_cnt; s_wr = wr_cnt;
      run_cmd(C_NOP, 3'd2, 3'd3, 3'd1, 1, "nop");
      check("nop_no_write", wr_cnt - s_wr, 0);
      check("nop_no_start", start_cnt - s_start, 0);
      check("nop_mem_kept", mem[1], 5);

      // Destination equals both sources.
      stub_lat = 4;
      run_cmd(C_MUL, 3'd1, 3'd1, 3'd1, 9, "mul_alias");
      ref_mem[1] = 25;
      check("alias_result", mem[1], 25);
      stub_lat = 3;

      // Multiplier never answers: timeout after TMO BUSY cycles.
      stub_mute = 1'b1;
      s_wr = wr_cnt;
      run_cmd(C_MUL, 3'd3, 3'd2, 3'd4, 3 + TMO + 1, "timeout");
      check("err_set", err, 1);
      check("err_time", err_cyc - acc_cyc - 1, 3 + TMO);
      check("timeout_no_write", wr_cnt - s_wr, 0);
      check("timeout_mem_kept", mem[4], ref_mem[4]);
      stub_mute = 1'b0;
      run_cmd(C_COPY, 3'd3, 3'd0, 3'd5, 4, "after_timeout");
      ref_mem[5] = 35;
      check("after_timeout_copy", mem[5], 35);
      check("err_sticky", err, 1);

      // Reset while waiting in BUSY.
      stub_mute = 1'b1;
      s_wr = wr_cnt; s_done = done_cnt;
      send(C_MUL, 3'd1, 3'd2, 3'd6);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", cmd_ready, 0);
      check("midrst_err", err, 0);
      check("midrst_outs", {ram_a_w, mul_start, done}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("midrst_ready_low", cmd_ready, 0);
      @(negedge clk);
      check("midrst_ready_high", cmd_ready, 1);
      repeat (25) @(negedge clk);
      check("midrst_no_done", done_cnt - s_done, 0);
      check("midrst_no_write", wr_cnt - s_wr, 0);
      check("midrst_mem_kept", mem[6], ref_mem[6]);
      stub_mute = 1'b0;

      // cmd_valid held across a MUL then a COPY.
      s_acc = acc_cnt; s_viol = ready_viol; s_done = done_cnt;
      n = 0;
      @(negedge clk);
      cmd_op = C_MUL; cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_dst = 3'd0; cmd_valid = 1'b1;
      while (acc_cnt == s_acc && n < 100) begin
         @(negedge clk);
         n++;
      end
      cmd_op = C_COPY; cmd_src1 = 3'd2; cmd_dst = 3'd6;
      while (acc_cnt == s_acc + 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      check("b2b_bounded", n < 100, 1);
      wait_done("b2b");
      check("b2b_copy_latency", done_cyc - acc_cyc - 1, 4);
      repeat (3) @(negedge clk);
      ref_mem[0] = 1225;
      ref_mem[6] = 49;
      check("b2b_accepts", acc_cnt - s_acc, 2);
      check("b2b_ready_low", ready_viol - s_viol, 0);
      check("b2b_dones", done_cnt - s_done, 2);
      check("b2b_mul", mem[0], 1225);
      check("b2b_copy", mem[6], 49);

      // Random commands against the word-level model.
      for (int k = 0; k < 8; k++) poke(ADDR'(k), rand_word());
      for (int t = 0; t < 30; t++) begin
         logic [1:0]      op;
         logic [ADDR-1:0] s1, s2, d;
         int              lat_m, exp_lat;
         op = 2'($urandom_range(0, 3));
         s1 = ADDR'($urandom_range(0, 7));
         s2 = ADDR'($urandom_range(0, 7));
         d  = ADDR'($urandom_range(0, 7));
         lat_m = $urandom_range(1, 6);
         stub_lat = lat_m;
         case (op)
            C_MUL:   begin ref_mem[d] = ref_mem[s1] * ref_mem[s2]; exp_lat = 5 + lat_m; end
            C_SQR:   begin ref_mem[d] = ref_mem[s1] * ref_mem[s1]; exp_lat = 5 + lat_m; end
            C_COPY:  begin ref_mem[d] = ref_mem[s1];               exp_lat = 4;         end
            default: exp_lat = 1;
         endcase
         run_cmd(op, s1, s2, d, exp_lat, "rand");
         check("rand_word", mem[d], ref_mem[d]);
      end
      for (int k = 0; k < 8; k++) check("final_mem", mem[k], ref_mem[k]);
      check("final_ram_b_w", bw_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
